// File: rtl/pc_gen_pkg.sv
// Shared encodings and default constants for the fetch-address generator.
package pc_gen_pkg;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD
    } state_t;

    // Kind of redirect held in the pending register.
    typedef enum logic [1:0] {
        RD_NONE,
        RD_BRANCH,
        RD_TRAP
    } redirect_kind_t;

    localparam int unsigned DEFAULT_INC        = 4;
    localparam int unsigned DEFAULT_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_gen_unit_pc_redirect_arb.sv
// Next-PC arbitration: trap > branch > pending > sequential > hold.
// Also owns the pending-redirect register and the alignment check.
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            boot,
    input  logic            advance,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_inc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned,
    output logic            redirect_pending
);

    localparam logic [XLEN-1:0] KEEP_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    redirect_kind_t  pend_kind, pend_kind_next;
    logic [XLEN-1:0] pend_addr, pend_addr_next;
    logic [XLEN-1:0] raw_target;
    logic            open;
    logic            apply;
    logic            mis_next;

    // Priority mux when the PC may move; otherwise capture redirects into pending.
    always_comb begin
        open           = ~stall & ~boot;
        apply          = 1'b0;
        raw_target     = pc;
        next_pc        = pc;
        pend_kind_next = pend_kind;
        pend_addr_next = pend_addr;
        if (open) begin
            // A fresh redirect in the consuming cycle discards the pending entry.
            pend_kind_next = RD_NONE;
            pend_addr_next = '0;
            if (trap) begin
                apply      = 1'b1;
                raw_target = trap_vector;
            end else if (pc_src) begin
                apply      = 1'b1;
                raw_target = pc_target;
            end else if (pend_kind != RD_NONE) begin
                apply      = 1'b1;
                raw_target = pend_addr;
            end
            if (apply) begin
                next_pc = raw_target & KEEP_MASK;
            end else if (advance) begin
                next_pc = pc_plus_inc;
            end
        end else begin
            if (trap) begin
                pend_kind_next = RD_TRAP;
                pend_addr_next = trap_vector;
            end else if (pc_src && (pend_kind != RD_TRAP)) begin
                pend_kind_next = RD_BRANCH;
                pend_addr_next = pc_target;
            end
        end
        mis_next = apply & (|(raw_target & ~KEEP_MASK));
    end

    // Pending register (raw target kept until applied) and misaligned pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_kind  <= RD_NONE;
            pend_addr  <= '0;
            misaligned <= 1'b0;
        end else begin
            pend_kind  <= pend_kind_next;
            pend_addr  <= pend_addr_next;
            misaligned <= mis_next;
        end
    end

    assign redirect_pending = (pend_kind != RD_NONE);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-address generator: boot/run/hold sequencing, PC register, IMEM handshake.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = DEFAULT_INC,
    parameter int unsigned     ALIGN_BITS   = DEFAULT_ALIGN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            if_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            redirect_pending
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] next_pc;
    logic            advance;
    logic            boot;

    assign pc_plus_inc = pc + XLEN'(INC);
    assign advance     = pc_valid & if_ready & ~stall;
    assign boot        = (state_q == ST_BOOT);

    // Next-state logic for the fetch sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (stall)  state_d = ST_HOLD;
            ST_HOLD: if (!stall) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // State, PC and registered fetch-valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= next_pc;
            pc_valid <= (state_d == ST_RUN);
        end
    end

    pc_redirect_arb #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_arb (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .boot             (boot),
        .advance          (advance),
        .pc               (pc),
        .pc_plus_inc      (pc_plus_inc),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .trap             (trap),
        .trap_vector      (trap_vector),
        .next_pc          (next_pc),
        .misaligned       (misaligned),
        .redirect_pending (redirect_pending)
    );

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed plus randomized bench for pc_gen_unit against a rule-level model.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst, stall, pc_src, trap, if_ready;
    logic [31:0] pc_target, trap_vector;
    logic [31:0] pc, pc_plus_inc;
    logic        pc_valid, misaligned, redirect_pending;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_valid, m_boot, m_have, m_is_trap, m_mis;
    logic [31:0] m_paddr;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INC          (4),
        .ALIGN_BITS   (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .trap             (trap),
        .trap_vector      (trap_vector),
        .if_ready         (if_ready),
        .pc               (pc),
        .pc_plus_inc      (pc_plus_inc),
        .pc_valid         (pc_valid),
        .misaligned       (misaligned),
        .redirect_pending (redirect_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 0; m_boot = 1; m_have = 0;
        m_is_trap = 0; m_paddr = 32'h0; m_mis = 0;
    endtask

    // One clock edge of the rules: priority redirect, pending capture, sequencing.
    task automatic model_step();
        logic [31:0] tgt;
        bit          hit;
        if (rst) begin
            model_reset();
            return;
        end
        m_mis = 0;
        hit   = 0;
        tgt   = 32'h0;
        if (!stall && !m_boot) begin
            if (trap)        begin hit = 1; tgt = trap_vector; end
            else if (pc_src) begin hit = 1; tgt = pc_target;   end
            else if (m_have) begin hit = 1; tgt = m_paddr;     end
            if (hit) begin
                m_pc  = tgt & 32'hFFFF_FFFC;
                m_mis = (tgt[1:0] != 2'b00);
            end else if (m_valid && if_ready) begin
                m_pc = m_pc + 32'd4;
            end
            m_have = 0;
        end else if (trap) begin
            m_have = 1; m_is_trap = 1; m_paddr = trap_vector;
        end else if (pc_src && !(m_have && m_is_trap)) begin
            m_have = 1; m_is_trap = 0; m_paddr = pc_target;
        end
        if (m_boot) begin
            m_boot  = 0;
            m_valid = 1;
        end else begin
            m_valid = !stall;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       pc,                     m_pc);
        chk({tag, ".valid"},    32'(pc_valid),          32'(m_valid));
        chk({tag, ".mis"},      32'(misaligned),        32'(m_mis));
        chk({tag, ".pending"},  32'(redirect_pending),  32'(m_have));
        chk({tag, ".plus_inc"}, pc_plus_inc,            m_pc + 32'd4);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; stall = 0; pc_src = 0; trap = 0; if_ready = 1;
        pc_target = 32'h0; trap_vector = 32'h0;
        model_reset();

        // Reset and boot
        tick("rst0"); chk("rst_pc", pc, 32'h0); chk("rst_valid", 32'(pc_valid), 32'd0);
        tick("rst1");
        rst = 0;
        #1 chk("boot_valid", 32'(pc_valid), 32'd0);
        tick("boot");  chk("run_pc0", pc, 32'h0); chk("run_valid", 32'(pc_valid), 32'd1);
        tick("seq4");  chk("seq_pc4", pc, 32'h4);
        tick("seq8");  chk("seq_pc8", pc, 32'h8);
        tick("seqc");  chk("seq_pcc", pc, 32'hC);
        tick("seq10"); chk("seq_pc10", pc, 32'h10);

        // Branch redirect with misaligned target
        pc_src = 1; pc_target = 32'hA1;
        tick("br_a1"); pc_src = 0;
        chk("br_pc_a0", pc, 32'hA0); chk("br_mis1", 32'(misaligned), 32'd1);
        tick("br_a4"); chk("br_pc_a4", pc, 32'hA4); chk("br_mis0", 32'(misaligned), 32'd0);
        pc_src = 1; pc_target = 32'h20;
        tick("br_20"); pc_src = 0;
        chk("br_pc_20", pc, 32'h20); chk("br_aligned", 32'(misaligned), 32'd0);

        // Redirect during stall
        stall = 1;
        tick("st1"); chk("st_frozen1", pc, 32'h20);
        pc_src = 1; pc_target = 32'h40;
        tick("st2"); pc_src = 0;
        chk("st_pend_set", 32'(redirect_pending), 32'd1);
        tick("st3"); chk("st_frozen3", pc, 32'h20);
        stall = 0;
        tick("unst"); chk("unst_pc40", pc, 32'h40); chk("unst_pend0", 32'(redirect_pending), 32'd0);

        // Priority: trap beats branch; pending trap beats later branch
        trap = 1; trap_vector = 32'h100; pc_src = 1; pc_target = 32'h200;
        tick("prio"); trap = 0; pc_src = 0;
        chk("prio_pc100", pc, 32'h100);
        stall = 1; trap = 1; trap_vector = 32'h300;
        tick("ptrap"); trap = 0; pc_src = 1; pc_target = 32'h400;
        tick("pbr"); pc_src = 0; stall = 0;
        tick("papply"); chk("ptrap_pc300", pc, 32'h300);

        // IMEM not ready: hold
        if_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick("nrdy");
            chk("nrdy_pc", pc, 32'h300); chk("nrdy_valid", 32'(pc_valid), 32'd1);
        end
        if_ready = 1;

        // Wrap-around
        pc_src = 1; pc_target = 32'hFFFF_FFF8;
        tick("wr0"); pc_src = 0; chk("wrap_f8", pc, 32'hFFFF_FFF8);
        tick("wr1"); chk("wrap_fc", pc, 32'hFFFF_FFFC); chk("wrap_inc", pc_plus_inc, 32'h0);
        tick("wr2"); chk("wrap_0", pc, 32'h0);

        // Asynchronous reset mid-operation with a pending redirect
        pc_src = 1; pc_target = 32'h54;
        tick("mr0"); pc_src = 0; chk("mr_pc54", pc, 32'h54);
        stall = 1; pc_src = 1; pc_target = 32'h80;
        tick("mr1"); pc_src = 0; chk("mr_pend", 32'(redirect_pending), 32'd1);
        #3 rst = 1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", 32'(pc_valid), 32'd0);
        chk("arst_pend", 32'(redirect_pending), 32'd0);
        model_reset();
        tick("mr2");
        rst = 0; stall = 0;
        tick("mr_boot"); chk("mr_boot_pc", pc, 32'h0);
        for (int i = 0; i < 4; i++) tick("mr_seq");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            stall       = ($urandom_range(0, 3) == 0);
            pc_src      = ($urandom_range(0, 4) == 0);
            trap        = ($urandom_range(0, 9) == 0);
            if_ready    = ($urandom_range(0, 3) != 0);
            pc_target   = $urandom;
            trap_vector = $urandom;
            tick("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised fetch-address generator. It is the next generation of the single-mode `address_generator` (PC+4 or branch target).
- Adds a stall hold, a trap redirect with priority, a pending-redirect latch that captures redirects arriving while stalled, a valid/ready handshake to instruction memory, and target-alignment enforcement.
- Sits at the head of the IF stage and drives the IMEM address and the IF/ID PC.

Parameters:
- XLEN, 32, width of PC and all address ports
- RESET_VECTOR, 32'h0000_0000, PC value held during and after reset
- INC, 4, sequential increment in bytes
- ALIGN_BITS, 2, number of low PC bits forced to zero on every redirect

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit hold request; PC must not advance
- pc_src  in  1  taken branch/jump redirect from EX
- pc_target  in  XLEN  branch/jump target
- trap  in  1  exception/interrupt redirect
- trap_vector  in  XLEN  trap handler address
- if_ready  in  1  IMEM accepts the current address
- pc  out  XLEN  current fetch address (registered)
- pc_plus_inc  out  XLEN  pc + INC, combinational, modulo 2^XLEN
- pc_valid  out  1  fetch request valid (registered)
- misaligned  out  1  one-cycle pulse: last applied redirect target had nonzero low bits
- redirect_pending  out  1  a redirect is latched awaiting un-stall

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc = RESET_VECTOR, pc_valid = 0, misaligned = 0, redirect_pending = 0.
  - Pending address cleared; state = BOOT.
- FSM states: BOOT, RUN, HOLD.
  - BOOT -> RUN on the first edge after rst deasserts; pc unchanged.
  - RUN -> HOLD when stall = 1 at an edge.
  - HOLD -> RUN when stall = 0 at an edge.
  - pc_valid = 1 exactly in RUN.
- advance = pc_valid & if_ready & ~stall.
- Next-PC priority when stall = 0 and state != BOOT:
  - trap -> trap_vector
  - else pc_src -> pc_target
  - else pending -> pending address
  - else advance -> pc + INC
  - else pc holds
- A redirect in RUN takes effect at the next edge regardless of if_ready. The in-flight request is abandoned; IMEM must tolerate this.
- Redirect while stall = 1 or in BOOT:
  - Latched into the pending register; redirect_pending = 1 from the next cycle.
  - A trap overwrites a pending branch. A branch does not overwrite a pending trap.
  - A later branch overwrites an earlier pending branch.
- The pending entry is consumed on the first edge with stall = 0 and state != BOOT; redirect_pending clears at that edge.
  - A fresh trap or pc_src in that same cycle wins, and the pending entry is discarded.
- Alignment:
  - Every applied redirect address has its low ALIGN_BITS cleared.
  - misaligned = 1 for exactly the one cycle following the edge that applied a target whose low bits were nonzero; otherwise 0.
  - Latched pending targets keep their raw value until applied.
- Arithmetic: pc + INC wraps modulo 2^XLEN; 0xFFFF_FFFC + 4 = 0x0000_0000. No flag is raised on wrap.
- trap and pc_src asserted in the same cycle: trap wins, pc_src is dropped, and nothing is latched for it.

Decomposition:
- Package pc_gen_pkg holds:
  - the state encoding (BOOT/RUN/HOLD)
  - the redirect-kind encoding (NONE/BRANCH/TRAP) used by the pending register
  - default INC and ALIGN_BITS constants
- One sub-module, pc_redirect_arb, contains:
  - the priority mux over trap/pc_src/pending/sequential
  - the pending register with its overwrite rules
  - the alignment masking and misaligned-flag generation
- The top level keeps the FSM, the PC register and the handshake.

Test Plan:
- Reset and boot:
  - Stimulus: rst = 1 for 2 cycles, then release with if_ready = 1.
  - Response: pc = 0x0 with pc_valid = 0 during reset and the BOOT cycle; pc_valid = 1 in the next cycle; then pc steps 0x0, 0x4, 0x8, 0xC on consecutive edges.
- Branch redirect:
  - Stimulus: pc_src = 1 for one cycle with pc_target = 0xA1 at pc = 0x10.
  - Response: next pc = 0xA0 with misaligned = 1 for one cycle; then 0xA4. pc_src = 1 with pc_target = 0x20 gives pc = 0x20 and misaligned = 0.
- Redirect during stall:
  - Stimulus: stall = 1 for 3 cycles with pc_src pulsed, pc_target = 0x40, in the 2nd stall cycle.
  - Response: pc frozen; redirect_pending = 1 from the next cycle; on un-stall, pc = 0x40 and redirect_pending = 0.
- Priority:
  - Stimulus: trap = 1 with trap_vector = 0x100 together with pc_src = 1, pc_target = 0x200.
  - Response: pc = 0x100.
  - Stimulus: a trap pending under stall followed by a branch under stall.
  - Response: the trap is still applied on un-stall.
- Handshake and wrap:
  - Stimulus: if_ready = 0 for 4 cycles.
  - Response: pc and pc_valid held.
  - Stimulus: run sequentially from 0xFFFF_FFF8.
  - Response: 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) with a pending redirect and pc = 0x54.
  - Response: pc = RESET_VECTOR, pc_valid = 0 and redirect_pending = 0 immediately; after release the pending target is never applied.
